look_ahead_adder: RTL and testbench

LOOK_AHEAD_ADDER -- requirements
Module: look_ahead_adder

---
 rtl/look_ahead_adder_pkg.sv | 35 +++
 rtl/look_ahead_adder_cla4.sv | 33 +++
 rtl/look_ahead_adder.sv | 135 +++++++++++++
 tb/tb_look_ahead_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/look_ahead_adder_pkg.sv
// Shared constants and the 4-input lookahead carry equation for the adder tree.
// Latency: none (combinational helper only).
// Backpressure: none.
package look_ahead_adder_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int GROUP_W       = 4;
    localparam int BLOCK_W       = 16;

    // Flattened sum-of-products carries c1..c4 from four (generate, propagate)
    // pairs and a carry-in; no term depends on a previously computed carry.
    function automatic logic [4:1] cla_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [4:1] c;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/look_ahead_adder_cla4.sv
// 4-bit carry-lookahead cell: internal carries plus group generate/propagate.
// Latency: combinational.
// Backpressure: none.
module cla4
    import look_ahead_adder_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:1] c,
    output logic       G,
    output logic       P
);

    logic [4:1] w_c;
    logic       w_unused_c4;

    assign w_c = cla_carries(g, p, cin);
    assign c   = w_c[3:1];

    // The carry out of this cell is formed one level up from G/P, so the
    // local c4 term is not needed here.
    assign w_unused_c4 = w_c[4];

    // Group generate/propagate depend only on g/p, never on cin, which keeps
    // the tree free of any path from a carry back into a G/P signal.
    assign G = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule

// File: rtl/look_ahead_adder.sv
// Registered WIDTH-bit unsigned adder built on a 3-level carry-lookahead tree
// (bit -> 4-bit group -> 16-bit block -> top); WIDTH = 16, 32, 48 or 64.
// Latency: 1 cycle, throughput 1/cycle, no handshake (no backpressure).
// Macro LOOK_AHEAD_ADDER_COUT_EN adds the registered carry-out port COUT.
module look_ahead_adder
    import look_ahead_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] SUM
`ifdef LOOK_AHEAD_ADDER_COUT_EN
    ,
    output logic             COUT
`endif
);

    localparam int NG  = WIDTH / GROUP_W;    // number of 4-bit groups
    localparam int NB  = WIDTH / BLOCK_W;    // number of 16-bit blocks (1..4)
    localparam int GPB = BLOCK_W / GROUP_W;  // groups per block

    // Bit level
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;      // carry into each bit
    logic [WIDTH-1:0] w_sum;

    // Group level
    logic [NG-1:0]    w_grp_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG-1:0]    w_grp_c;  // carry into each group

    // Block level
    logic [NB-1:0]    w_blk_g;
    logic [NB-1:0]    w_blk_p;
    logic [NB-1:0]    w_blk_c;  // carry into each block

    // Top level
    logic [3:0]       w_top_gi;
    logic [3:0]       w_top_pi;
    logic [3:1]       w_top_c;
    logic             w_top_g;
    logic             w_top_p;
    logic             w_unused;

    logic [WIDTH-1:0] r_sum;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Level 1: one cell per 4-bit group yields bit carries and group G/P.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4 u_cla4 (
            .g   (w_g[gi*GROUP_W +: GROUP_W]),
            .p   (w_p[gi*GROUP_W +: GROUP_W]),
            .cin (w_grp_c[gi]),
            .c   (w_c[gi*GROUP_W+1 +: GROUP_W-1]),
            .G   (w_grp_g[gi]),
            .P   (w_grp_p[gi])
        );
        assign w_c[gi*GROUP_W] = w_grp_c[gi];
    end

    // Level 2: one cell per 16-bit block combines its four group G/P values.
    for (genvar bi = 0; bi < NB; bi++) begin : g_blk
        cla4 u_cla4 (
            .g   (w_grp_g[bi*GPB +: GPB]),
            .p   (w_grp_p[bi*GPB +: GPB]),
            .cin (w_blk_c[bi]),
            .c   (w_grp_c[bi*GPB+1 +: GPB-1]),
            .G   (w_blk_g[bi]),
            .P   (w_blk_p[bi])
        );
        assign w_grp_c[bi*GPB] = w_blk_c[bi];
    end

    // Pad unused top-level slots with g=0/p=1 so they pass the real carry
    // straight through; top G is then the carry out of the MSB for any WIDTH.
    always_comb begin
        w_top_gi         = '0;
        w_top_pi         = '1;
        w_top_gi[NB-1:0] = w_blk_g;
        w_top_pi[NB-1:0] = w_blk_p;
    end

    // Level 3: combine block G/P with the fixed zero carry-in.
    cla4 u_top (
        .g   (w_top_gi),
        .p   (w_top_pi),
        .cin (1'b0),
        .c   (w_top_c),
        .G   (w_top_g),
        .P   (w_top_p)
    );

    assign w_blk_c[0] = 1'b0;
    for (genvar k = 1; k < NB; k++) begin : g_blk_cin
        assign w_blk_c[k] = w_top_c[k];
    end

    // Top P, padded-slot carries and (without COUT) top G have no consumer.
    assign w_unused = ^{w_top_c, w_top_p, w_top_g};

    assign w_sum = w_p ^ w_c;

    // Capture the sum one cycle after its operands; reset clears it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign SUM = r_sum;

`ifdef LOOK_AHEAD_ADDER_COUT_EN
    logic r_cout;

    // Carry out of the MSB, aligned with the SUM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cout <= 1'b0;
        end else begin
            r_cout <= w_top_g;
        end
    end

    assign COUT = r_cout;
`endif

endmodule

// File: tb/tb_look_ahead_adder.sv
// Directed and random self-checking bench for look_ahead_adder at WIDTH=64.
// Checks reset, one-cycle latency, carry chains across group/block bounds.
// Works with or without LOOK_AHEAD_ADDER_COUT_EN defined.
module tb_look_ahead_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] SUM;
`ifdef LOOK_AHEAD_ADDER_COUT_EN
    logic        COUT;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [63:0] prev_sum;
    logic        prev_cout;

    always #5 clk = ~clk;

    look_ahead_adder #(
        .WIDTH (64)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .SUM  (SUM)
`ifdef LOOK_AHEAD_ADDER_COUT_EN
        ,
        .COUT (COUT)
`endif
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge. Applies operands, confirms the
    // output still holds the previous result mid-cycle, then checks the new
    // result just after the next edge.
    task automatic drive(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] es, input logic ec);
        A = a;
        B = b;
        #2;
        check64({tag, "/hold"}, SUM, prev_sum);
`ifdef LOOK_AHEAD_ADDER_COUT_EN
        check1({tag, "/hold_cout"}, COUT, prev_cout);
`endif
        @(posedge clk);
        #1;
        check64(tag, SUM, es);
`ifdef LOOK_AHEAD_ADDER_COUT_EN
        check1({tag, "/cout"}, COUT, ec);
`endif
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] rs;
        logic        rc;

        // Reset held across edges with nonzero operands present
        rst = 1'b1;
        A   = 64'hFFFF_FFFF_FFFF_FFFF;
        B   = 64'h0000_0000_0000_0001;
        repeat (2) @(posedge clk);
        #1;
        check64("reset_sum", SUM, 64'h0);
`ifdef LOOK_AHEAD_ADDER_COUT_EN
        check1("reset_cout", COUT, 1'b0);
`endif
        rst       = 1'b0;
        prev_sum  = 64'h0;
        prev_cout = 1'b0;

        // Directed vectors, applied back to back on consecutive cycles
        drive("zero",       64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0);
        drive("max_pos",    64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        drive("wrap_full",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1);
        drive("blk32",      64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 1'b0);
        drive("blk16",      64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 1'b0);
        drive("grp4",       64'h0000_0000_0000_000F, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0010, 1'b0);
        drive("no_carry",   64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drive("msb_only",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);
        drive("lanes16",    64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 64'h0100_0100_0100_0100, 1'b0);
        drive("blk16_x2",   64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 64'h0001_0000_0001_0000, 1'b0);
        drive("max_max",    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

        // Asynchronous reset mid-cycle with SUM nonzero and an add in flight
        A = 64'h0000_0000_0000_0005;
        B = 64'h0000_0000_0000_0007;
        #2;
        rst = 1'b1;
        #1;
        check64("async_rst", SUM, 64'h0);
`ifdef LOOK_AHEAD_ADDER_COUT_EN
        check1("async_rst_cout", COUT, 1'b0);
`endif
        @(posedge clk);
        #1;
        check64("rst_hold", SUM, 64'h0);
        rst       = 1'b0;
        prev_sum  = 64'h0;
        prev_cout = 1'b0;
        drive("post_rst",   64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_000C, 1'b0);

        // Random back-to-back stream against a reference add
        for (int i = 0; i < 10000; i++) begin
            ra       = {$urandom, $urandom};
            rb       = {$urandom, $urandom};
            {rc, rs} = {1'b0, ra} + {1'b0, rb};
            drive("rand", ra, rb, rs, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
